// File: rtl/systolic_ctrl.sv
// Job sequencer for the weight-stationary systolic array: loads one weight tile
// row by row, streams activation vectors, drains the pipeline and tags results.
module systolic_ctrl #(
  parameter int ARRAY_ROW = 12,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 12,
  parameter int OUT_LAT   = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_num_vec,
  input  logic [ADDR_W-1:0]    cfg_w_base,
  input  logic [ADDR_W-1:0]    cfg_a_base,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [ADDR_W-1:0]    w_rd_addr,
  output logic [ARRAY_ROW-1:0] row_load_en,
  output logic                 a_rd_en,
  output logic [ADDR_W-1:0]    a_rd_addr,
  output logic                 en_compute,
  output logic                 out_valid,
  output logic [LEN_W-1:0]     out_idx
);

  localparam int ROW_W = $clog2(ARRAY_ROW);
  localparam int LAT_W = 8;
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(ARRAY_ROW - 1);
  localparam logic [ROW_W-1:0]     ROW_INC  = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [ARRAY_ROW-1:0] ROW_ONE  = {{(ARRAY_ROW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]       CNT_INC  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]     IDX_INC  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]       LAT_EXT  = (LEN_W+1)'(OUT_LAT);
  localparam logic [LAT_W-1:0]     LAT_LOAD = LAT_W'(OUT_LAT);
  localparam logic [LAT_W-1:0]     LAT_DEC  = {{(LAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [ROW_W-1:0]     row_cnt_r, row_cnt_s;
  logic [LEN_W:0]       vec_cnt_r, vec_cnt_s;
  logic [LAT_W-1:0]     lat_cnt_r, lat_cnt_s;
  logic [LEN_W:0]       ec_cnt_r, ec_cnt_s;
  logic [LEN_W-1:0]     num_vec_r, num_vec_s;
  logic [ADDR_W-1:0]    a_base_r, a_base_s;
  logic [LEN_W:0]       ov_end_s;

  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 w_rd_en_r, w_rd_en_s;
  logic [ADDR_W-1:0]    w_rd_addr_r, w_rd_addr_s;
  logic [ARRAY_ROW-1:0] row_load_en_r, row_load_en_s;
  logic                 a_rd_en_r, a_rd_en_s;
  logic [ADDR_W-1:0]    a_rd_addr_r, a_rd_addr_s;
  logic                 en_compute_r, en_compute_s;
  logic                 out_valid_r, out_valid_s;
  logic [LEN_W-1:0]     out_idx_r, out_idx_s;

  // Next-state and next-output logic; every output is computed one cycle ahead
  always_comb begin
    state_s       = state_r;
    row_cnt_s     = row_cnt_r;
    vec_cnt_s     = vec_cnt_r;
    lat_cnt_s     = lat_cnt_r;
    num_vec_s     = num_vec_r;
    a_base_s      = a_base_r;
    w_rd_en_s     = 1'b0;
    w_rd_addr_s   = '0;
    a_rd_en_s     = 1'b0;
    a_rd_addr_s   = '0;
    en_compute_s  = 1'b0;
    ec_cnt_s      = en_compute_r ? (ec_cnt_r + CNT_INC) : ec_cnt_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = LOAD_W;
          num_vec_s   = cfg_num_vec;
          a_base_s    = cfg_a_base;
          row_cnt_s   = '0;
          ec_cnt_s    = '0;
          w_rd_en_s   = 1'b1;
          w_rd_addr_s = cfg_w_base;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_W: begin
        if (row_cnt_r == ROW_LAST) begin
          if (num_vec_r != '0) begin
            state_s     = STREAM;
            vec_cnt_s   = '0;
            a_rd_en_s   = 1'b1;
            a_rd_addr_s = a_base_r;
          end else begin
            // Empty job: a zero-length drain goes straight to DONE
            state_s   = DRAIN;
            lat_cnt_s = '0;
          end
        end else begin
          row_cnt_s   = row_cnt_r + ROW_INC;
          w_rd_en_s   = 1'b1;
          w_rd_addr_s = w_rd_addr_r + ADDR_INC;
        end
      end
      STREAM: begin
        en_compute_s = 1'b1;
        if ((vec_cnt_r + CNT_INC) < {1'b0, num_vec_r}) begin
          vec_cnt_s   = vec_cnt_r + CNT_INC;
          a_rd_en_s   = 1'b1;
          a_rd_addr_s = a_rd_addr_r + ADDR_INC;
        end else begin
          state_s   = DRAIN;
          lat_cnt_s = LAT_LOAD;
        end
      end
      DRAIN: begin
        if (lat_cnt_r != '0) begin
          en_compute_s = 1'b1;
          lat_cnt_s    = lat_cnt_r - LAT_DEC;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    row_load_en_s = (state_r == LOAD_W) ? (ROW_ONE << row_cnt_r) : '0;

    // ec_cnt_s is the number of en_compute cycles seen so far, this one included
    ov_end_s    = {1'b0, num_vec_r} + LAT_EXT;
    out_valid_s = en_compute_r && (ec_cnt_s >= LAT_EXT) && (ec_cnt_s < ov_end_s);
    if (out_valid_s) begin
      out_idx_s = out_valid_r ? (out_idx_r + IDX_INC) : '0;
    end else begin
      out_idx_s = '0;
    end

    busy_s = (state_s == LOAD_W) || (state_s == STREAM) || (state_s == DRAIN);
    done_s = (state_s == DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      row_cnt_r     <= '0;
      vec_cnt_r     <= '0;
      lat_cnt_r     <= '0;
      ec_cnt_r      <= '0;
      num_vec_r     <= '0;
      a_base_r      <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      w_rd_en_r     <= 1'b0;
      w_rd_addr_r   <= '0;
      row_load_en_r <= '0;
      a_rd_en_r     <= 1'b0;
      a_rd_addr_r   <= '0;
      en_compute_r  <= 1'b0;
      out_valid_r   <= 1'b0;
      out_idx_r     <= '0;
    end else begin
      state_r       <= state_s;
      row_cnt_r     <= row_cnt_s;
      vec_cnt_r     <= vec_cnt_s;
      lat_cnt_r     <= lat_cnt_s;
      ec_cnt_r      <= ec_cnt_s;
      num_vec_r     <= num_vec_s;
      a_base_r      <= a_base_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      w_rd_en_r     <= w_rd_en_s;
      w_rd_addr_r   <= w_rd_addr_s;
      row_load_en_r <= row_load_en_s;
      a_rd_en_r     <= a_rd_en_s;
      a_rd_addr_r   <= a_rd_addr_s;
      en_compute_r  <= en_compute_s;
      out_valid_r   <= out_valid_s;
      out_idx_r     <= out_idx_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign w_rd_en     = w_rd_en_r;
  assign w_rd_addr   = w_rd_addr_r;
  assign row_load_en = row_load_en_r;
  assign a_rd_en     = a_rd_en_r;
  assign a_rd_addr   = a_rd_addr_r;
  assign en_compute  = en_compute_r;
  assign out_valid   = out_valid_r;
  assign out_idx     = out_idx_r;

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the 12x16 weight-stationary systolic array.
- On `start`, it loads one weight tile row by row from the weight buffer (one row per cycle via `row_load_en`).
- It then streams `cfg_num_vec` activation vectors from the activation buffer while holding `en_compute` through the pipeline drain.
- It flags each valid bottom-row partial-sum vector with an index and pulses `done`. It sits between the layer scheduler and the array/buffer pair.

Parameters:
- ARRAY_ROW, 12, number of PE rows; width of `row_load_en`.
- ADDR_W, 10, width of the weight and activation buffer addresses.
- LEN_W, 12, width of the vector count and output index.
- OUT_LAT, 28, cycles from the first `en_compute` cycle to the first valid `out_psum_vec`. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_num_vec  in  LEN_W  number of activation vectors; 0 is legal.
- cfg_w_base  in  ADDR_W  weight buffer address of weight row 0.
- cfg_a_base  in  ADDR_W  activation buffer address of vector 0.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- w_rd_en  out  1  weight buffer read strobe; buffer read latency is 1 cycle.
- w_rd_addr  out  ADDR_W  weight buffer read address.
- row_load_en  out  ARRAY_ROW  one-hot array row load enable.
- a_rd_en  out  1  activation buffer read strobe; read latency is 1 cycle.
- a_rd_addr  out  ADDR_W  activation buffer read address.
- en_compute  out  1  array global compute enable.
- out_valid  out  1  array `out_psum_vec` holds a valid result.
- out_idx  out  LEN_W  index of the vector the current result belongs to.

Behaviour:
- Reset (async, any state): state goes to IDLE. All outputs are 0: `busy`, `done`, `w_rd_en`, `w_rd_addr`, `row_load_en`, `a_rd_en`, `a_rd_addr`, `en_compute`, `out_valid`, `out_idx`. Reset mid-job abandons the job with no `done`.
- All outputs are registered.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - When `start`=1 at cycle T, latch the three cfg values and go to LOAD_W.
  - `busy`=1 from T+1 until the cycle before `done`.
  - cfg changes after T have no effect.
- LOAD_W, cycles T+1..T+12:
  - `w_rd_en`=1, `w_rd_addr` = `w_base` + r for r = 0..11.
  - `row_load_en` = (1<<r) one cycle later (T+2..T+13), aligned with the buffer data.
  - Exactly one bit of `row_load_en` is high at any time; it is 0 outside T+2..T+13.
- STREAM, cycles T+13..T+12+N, where N = latched `cfg_num_vec`:
  - `a_rd_en`=1, `a_rd_addr` = `a_base` + i for i = 0..N-1.
  - Address addition wraps modulo 2^ADDR_W.
- `en_compute`:
  - High continuously for N+OUT_LAT cycles, T+14..T+13+N+OUT_LAT, covering STREAM data and DRAIN.
  - It never drops mid-job.
- `out_valid`:
  - High for cycles T+14+OUT_LAT..T+13+OUT_LAT+N.
  - `out_idx` counts 0..N-1 on those cycles and is held at 0 otherwise.
- DRAIN: a down-counter loaded with OUT_LAT. Exit to DONE occurs after the last `en_compute` cycle.
- DONE:
  - `done`=1 for exactly one cycle at T+14+N+OUT_LAT, with `busy`=0 in that same cycle.
  - Then return to IDLE.
  - `start` asserted during DONE is ignored. It is accepted in the following IDLE cycle at the earliest.
- N=0:
  - LOAD_W is performed normally.
  - No `a_rd_en`, no `en_compute`, no `out_valid`.
  - `done` pulses at T+14.
- `start` while not in IDLE is ignored, with no queuing.
- N = 2^LEN_W-1 must run to completion without counter overflow. Counters are LEN_W+1 bits where needed.
- `w_rd_en` and `a_rd_en` are never high in the same cycle.

Test Plan:
- Basic job: reset, then `start` at T=10 with N=4, `w_base`=0x010, `a_base`=0x100, OUT_LAT=28.
  - `w_rd_addr` 0x010..0x01B on cycles 11..22.
  - `row_load_en` 0x001..0x800 on cycles 12..23.
  - `a_rd_addr` 0x100..0x103 on cycles 23..26.
  - `en_compute` high on cycles 24..55.
  - `out_valid` high on 52..55 with `out_idx` 0..3.
  - `done` at 56; `busy` high on 11..55.
- Zero-length job: N=0, `start` at T=5.
  - `row_load_en` walks one-hot on 7..18.
  - `a_rd_en`, `en_compute` and `out_valid` never assert.
  - `done` at 19.
- Address wrap: `a_base`=0x3FE, N=4 → `a_rd_addr` = 0x3FE, 0x3FF, 0x000, 0x001.
- Start while busy: `start` held high for the whole job, N=2.
  - Exactly one `done` pulse.
  - The next job's `w_rd_en` first appears no earlier than 2 cycles after `done`.
  - cfg changes made mid-job do not alter addresses.
- Reset mid-job: assert `rst_n`=0 during STREAM at vector 2 of N=8.
  - All outputs go to 0 immediately (asynchronously).
  - After release with no `start`, no activity and no `done`.
  - A new `start` then produces a full LOAD_W sequence.
- Invariant checks on all runs:
  - `row_load_en` is one-hot or zero.
  - `en_compute` is a single contiguous pulse per job.
  - The `out_valid` count equals N.
